// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NREQ producers.
// A grant is held until the burst's last beat or MAX_BURST beats, then one IDLE cycle re-arbitrates.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DW-1:0]             fifo_din,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      burst_done
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            burst_done_q, burst_done_d;

  logic [DW-1:0]   data_arr [NREQ];
  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0] valid_rot;
  int              pick_off;
  int              pick_int;
  logic [IW-1:0]   pick;
  logic            accept;
  logic            end_burst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DW +: DW];
      assign req_ready[gi] = (state_q == BURST) && (grant_q == IW'(gi)) && !fifo_full;
    end
  endgenerate

  // Rotate the valid vector so bit 0 is the requester right after the last grant;
  // the lowest set bit is then the round-robin winner.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = NREQ'(valid_dbl >> (int'(last_grant_q) + 1));

  always_comb begin
    pick_off = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) pick_off = i;
    end
    pick_int = (int'(last_grant_q) + 1 + pick_off) % NREQ;
  end

  assign pick = IW'(pick_int);

  assign accept    = (state_q == BURST) && req_valid[grant_q] && !fifo_full;
  assign end_burst = accept && (req_last[grant_q] || (beat_cnt_q == CW'(MAX_BURST - 1)));

  assign fifo_wen   = accept;
  assign fifo_din   = (state_q == BURST) ? data_arr[grant_q] : '0;
  assign busy       = (state_q == BURST);
  assign grant_id   = grant_q;
  assign burst_done = burst_done_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (end_burst) begin
          last_grant_d = grant_q;
          burst_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NREQ - 1);
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares the single write port of the 16-deep x 32-bit synchronous FIFO between NREQ producers.
- Each producer offers beats on a valid/ready interface. The arbiter grants one producer at a time and holds the grant until that producer's burst ends.
- It drives the FIFO din/wen directly and uses the FIFO full flag as backpressure.
- It sits between the producer blocks and the FIFO write side. The FIFO read side is not touched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width; must match the FIFO data width.
- MAX_BURST, 8, maximum beats per grant before forced release (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DW  flattened data; requester i occupies bits [i*DW +: DW].
- req_last  in  NREQ  per-requester last-beat-of-burst flag, qualified by req_valid.
- req_ready  out  NREQ  per-requester beat accepted this cycle when valid&ready.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wen  out  1  FIFO write enable.
- fifo_din  out  DW  FIFO write data.
- grant_id  out  clog2(NREQ)  index of the currently granted requester (registered).
- busy  out  1  high while in BURST.
- burst_done  out  1  one-cycle pulse registered on the cycle after a burst's final beat is accepted.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant_id=0, last_grant=NREQ-1 (requester 0 has first priority).
  - beat_cnt=0, burst_done=0.
  - Combinational outputs are forced low by state: req_ready=0, fifo_wen=0, busy=0, fifo_din=0.
- States: IDLE, BURST.
- IDLE:
  - req_ready=0, fifo_wen=0.
  - If any req_valid is high, pick the first valid requester scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - Register the pick into grant_id, clear beat_cnt, and go to BURST next cycle.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
- BURST, with g = grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - accept = req_valid[g] & !fifo_full.
  - fifo_wen = accept; fifo_din = req_data[g] (combinational, same cycle).
  - Writes are never issued while fifo_full=1, so the FIFO never sees wen with full.
  - On accept: beat_cnt increments.
  - If req_last[g] is high or beat_cnt==MAX_BURST-1 on an accepted beat: last_grant<=g, go to IDLE, burst_done=1 next cycle.
- Mid-burst conditions:
  - If req_valid[g] drops mid-burst, the grant is held; the arbiter waits with no timeout.
  - If fifo_full is high, the grant is held with zero writes; the requester must hold its data stable while not ready.
  - Other requesters' req_valid have no effect during BURST.
- Back-to-back bursts: at least one IDLE cycle separates them.
  - With all requesters continuously valid, grant order is 0,1,2,3,0,... and the pattern is BURST(s), IDLE, BURST(s), ...
- Fairness: a requester that is valid in IDLE is granted within NREQ-1 intervening bursts.
- Forced release: a requester still presenting beats at MAX_BURST loses the grant. Its next beat waits for re-arbitration and req_last is not implied.
- beat_cnt width is clog2(MAX_BURST)+1; it never wraps within a burst.
- Reset asserted mid-burst:
  - fifo_wen and req_ready drop in the same cycle.
  - The partially transferred burst is abandoned; beats already accepted remain in the FIFO.
  - After release, arbitration restarts from requester 0.

Test Plan:
- Single requester: reset, req 1 sends 3 beats 0xA0,0xA1,0xA2 with last on the 3rd.
  - Required: grant_id=1 one cycle after valid; fifo_wen high 3 consecutive cycles with those data.
  - Required: burst_done pulses once; state returns to IDLE.
- Round-robin: requesters 0-3 all valid with 1-beat bursts (last=1) from reset.
  - Required: grant order 0,1,2,3,0; each grant is followed by exactly one fifo_wen; an IDLE cycle occurs between grants.
- Backpressure: req 2 is in a 4-beat burst; fifo_full=1 for 5 cycles after beat 2.
  - Required: req_ready[2]=0 and fifo_wen=0 for those 5 cycles.
  - Required: beats 3-4 are written after full drops; no beat is lost or duplicated.
- Forced release: req 0 sends 10 beats with last never set, MAX_BURST=8.
  - Required: 8 writes, then IDLE, then req 0 is re-granted only after other valid requesters are served.
  - Required: the remaining 2 beats are written in the next grant.
- Valid gap: req 3 is granted, then deasserts valid for 4 cycles between beats while req 0 is valid.
  - Required: grant stays at 3; no writes during the gap; req_ready[0]=0 throughout.
- Async reset mid-burst: assert rst between clock edges during beat 2 of 5.
  - Required: fifo_wen and busy go low immediately, before the next edge; after release the first grant goes to requester 0 when it is valid.
